// File: rtl/cpu_defs.sv
// ---------------------------------------------------------------------------
// cpu_defs
// Shared constants for the instruction/data fetch front end.
//   DEFAULT_DEPTH  : default number of outstanding requests plus buffered
//                    responses in the SRAM-like master.
//   DEFAULT_DATA_W : default response data width.
//   cnt_width()    : width of a counter that must hold 0..depth inclusive.
// ---------------------------------------------------------------------------
package cpu_defs;

    localparam int DEFAULT_DEPTH  = 2;
    localparam int DEFAULT_DATA_W = 32;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Small first-word-fall-through FIFO holding returned read data until the
// pipeline consumes it. The head entry is visible on dout the cycle after it
// is written.
// Ports:
//   clk, resetn   : clock, asynchronous active-low reset
//   clr           : synchronous clear, wins over push/pop in the same cycle
//   push, din     : write one entry
//   pop           : consume head entry (ignored when empty)
//   dout          : head entry
//   count         : number of valid entries (0..DEPTH)
// ---------------------------------------------------------------------------
module sync_fifo
    import cpu_defs::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          clr,
    input  logic                          push,
    input  logic [DATA_W-1:0]             din,
    input  logic                          pop,
    output logic [DATA_W-1:0]             dout,
    output logic [cnt_width(DEPTH)-1:0]   count
);

    localparam int CW = cnt_width(DEPTH);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    // DEPTH is a power of two, so pointers wrap naturally; a single-entry
    // FIFO keeps its pointers pinned at zero.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (DEPTH == 1) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push && !clr;
    assign do_pop  = pop && !clr && (count != '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/sram_like_master.sv
// ---------------------------------------------------------------------------
// sram_like_master
// Turns a "pipeline needs access <unique_id>" level into SRAM-like request
// handshakes, keeps up to DEPTH accesses outstanding or buffered, and hands
// responses back in request order. A flush discards everything pending:
// responses still on the bus are counted and thrown away as they return.
// Ports:
//   clk, resetn          : clock, asynchronous active-low reset
//   need_req, unique_id  : pipeline wants the access tagged unique_id
//   flush                : cancel in-flight and buffered responses
//   busy                 : stall to the pipeline
//   req, addr_ok         : SRAM-like address phase
//   data_ok, rdata       : SRAM-like data phase
//   rsp_valid, rsp_data  : head of the response buffer
//   rsp_pop              : consume head response
// ---------------------------------------------------------------------------
module sram_like_master
    import cpu_defs::*;
#(
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int ID_W      = 32,
    parameter int WAIT_DATA = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              need_req,
    input  logic [ID_W-1:0]   unique_id,
    input  logic              flush,
    output logic              busy,
    output logic              req,
    input  logic              addr_ok,
    input  logic              data_ok,
    input  logic [DATA_W-1:0] rdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              rsp_pop
);

    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [CW-1:0]   inflight;
    logic [CW-1:0]   inflight_next;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   fifo_cnt;
    logic            issued_v;
    logic [ID_W-1:0] issued_id;

    logic new_acc;
    logic credit_ok;
    logic accept;
    logic dok;
    logic drop;
    logic push;
    logic pop;

    assign new_acc   = need_req && (!issued_v || (unique_id != issued_id));
    // Every outstanding request owns a FIFO slot, so the FIFO cannot overflow.
    assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_cnt}) < DEPTH_C;
    assign req       = new_acc && credit_ok;
    assign accept    = req && addr_ok;

    // data_ok with nothing outstanding is a bus protocol error; ignore it.
    assign dok  = data_ok && (inflight != '0);
    assign drop = dok && (drop_cnt != '0);
    assign push = dok && (drop_cnt == '0) && !flush;
    assign pop  = rsp_pop && rsp_valid && !flush;

    assign inflight_next = inflight + CW'(accept) - CW'(dok);
    assign rsp_valid     = (fifo_cnt != '0);

    // Responses return in order, so the most recently issued access has its
    // data buffered (or already consumed) exactly when nothing is in flight.
    if (WAIT_DATA != 0) begin : g_busy_wait
        assign busy = need_req &&
                      !(issued_v && (unique_id == issued_id) && (inflight == '0));
    end else begin : g_busy_addr
        assign busy = need_req && new_acc;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inflight  <= '0;
            drop_cnt  <= '0;
            issued_v  <= 1'b0;
            issued_id <= '0;
        end else begin
            inflight <= inflight_next;
            if (flush) begin
                // Whatever is still outstanding after this edge belongs to
                // cancelled accesses and must be discarded on return.
                drop_cnt <= inflight_next;
                issued_v <= 1'b0;
            end else begin
                if (drop) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
                if (accept) begin
                    issued_v  <= 1'b1;
                    issued_id <= unique_id;
                end
            end
        end
    end

    sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_rsp_fifo (
        .clk    (clk),
        .resetn (resetn),
        .clr    (flush),
        .push   (push),
        .din    (rdata),
        .pop    (pop),
        .dout   (rsp_data),
        .count  (fifo_cnt)
    );

endmodule
